// File: rtl/nand_cpu_pkg.sv
// Shared CPU types: datapath width, register address width and the writeback queue entry.
package nand_cpu_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int RF_AW      = $clog2(DATA_WIDTH);
    localparam int WB_DEPTH   = 4;

    typedef struct packed {
        logic                  wr;
        logic [RF_AW-1:0]      addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  ps_wr;
        logic                  ps;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_ifc.sv
// Register-file write port: one GPR write and one predicate/status write per cycle.
interface regfile_write_ifc;
    import nand_cpu_pkg::*;

    logic                  write;
    logic [DATA_WIDTH-1:0] rw;
    logic [RF_AW-1:0]      rw_addr;
    logic                  ps_write;
    logic                  ps;

    modport out  (output write, rw, rw_addr, ps_write, ps);
    modport sink (input  write, rw, rw_addr, ps_write, ps);
endinterface

// File: rtl/wb_queue.sv
// In-order registered FIFO of writeback entries; exposes every slot and its age rank for lookups.
module wb_queue
    import nand_cpu_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output wb_entry_t       head,
    output wb_entry_t       slots   [DEPTH],
    output logic [PW-1:0]   age_idx [DEPTH],
    output logic [DEPTH-1:0] age_vld
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;
    logic          do_push;

    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_idx[i] = rd_ptr_q + PW'(i);
            age_vld[i] = CW'(i) < count_q;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
    assign slots = mem_q;

endmodule

// File: rtl/regfile_writeback.sv
// Writeback queue feeding the register file, with youngest-first forwarding of pending writes.
module regfile_writeback
    import nand_cpu_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    parameter  int AW    = RF_AW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_write,
    input  logic [DATA_WIDTH-1:0] in_rw,
    input  logic [AW-1:0]         in_rw_addr,
    input  logic                  in_ps_write,
    input  logic                  in_ps,
    input  logic                  hold,
    regfile_write_ifc.out         w,
    input  logic [AW-1:0]         rt_addr,
    output logic                  fwd_ra_hit,
    output logic [DATA_WIDTH-1:0] fwd_ra,
    output logic                  fwd_rt_hit,
    output logic [DATA_WIDTH-1:0] fwd_rt,
    output logic                  fwd_ps_hit,
    output logic                  fwd_ps,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        w_entry;
    wb_entry_t        scan;
    wb_entry_t        slots   [DEPTH];
    logic [PW-1:0]    age_idx [DEPTH];
    logic [DEPTH-1:0] age_vld;
    logic             push;
    logic             drain;

    assign in_ready = (count != CW'(DEPTH)) || !hold;
    assign drain    = (count != '0) && !hold;
    assign empty    = (count == '0);

    // Beats that write nothing are accepted but never occupy a slot.
    assign push = in_valid && in_ready && (in_write || in_ps_write);

    always_comb begin
        push_entry       = '0;
        push_entry.wr    = in_write;
        push_entry.addr  = in_rw_addr;
        push_entry.data  = in_rw;
        push_entry.ps_wr = in_ps_write;
        push_entry.ps    = in_ps;
    end

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .count      (count),
        .head       (head),
        .slots      (slots),
        .age_idx    (age_idx),
        .age_vld    (age_vld)
    );

    assign w_entry    = drain ? head : '0;
    assign w.write    = w_entry.wr;
    assign w.rw       = w_entry.data;
    assign w.rw_addr  = w_entry.addr;
    assign w.ps_write = w_entry.ps_wr;
    assign w.ps       = w_entry.ps;

    // Walk oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        scan       = '0;
        fwd_ra_hit = 1'b0;
        fwd_ra     = '0;
        fwd_rt_hit = 1'b0;
        fwd_rt     = '0;
        fwd_ps_hit = 1'b0;
        fwd_ps     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            scan = slots[age_idx[i]];
            if (age_vld[i]) begin
                if (scan.wr && (scan.addr == '0)) begin
                    fwd_ra_hit = 1'b1;
                    fwd_ra     = scan.data;
                end
                if (scan.wr && (scan.addr == rt_addr)) begin
                    fwd_rt_hit = 1'b1;
                    fwd_rt     = scan.data;
                end
                if (scan.ps_wr) begin
                    fwd_ps_hit = 1'b1;
                    fwd_ps     = scan.ps;
                end
            end
        end
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback queue that is the writing end of the register-file write interface. It accepts results from the execute stage over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle onto `regfile_write_ifc`. While results sit in the queue, it forwards their values to the read side so that a read of `ra`, `rt` or `ps` never sees a stale register.

## Interface

Parameters
- `DEPTH`, default 4: queue entries; power of two, minimum 2.
- `AW`, default `$clog2(`DATA_WIDTH)`: register address width, equal to the `rw_addr` width of `regfile_write_ifc`.

Ports
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  execute stage offers a result.
- `in_ready`  out  1  queue accepts this cycle.
- `in_write`  in  1  result writes a GPR.
- `in_rw`  in  `DATA_WIDTH`  GPR data.
- `in_rw_addr`  in  AW  GPR address.
- `in_ps_write`  in  1  result writes the predicate/status bit.
- `in_ps`  in  1  predicate value.
- `hold`  in  1  suppress draining; the regfile write port is owned elsewhere this cycle.
- `w`  `regfile_write_ifc.out`  —  drives `write`, `rw`, `rw_addr`, `ps_write`, `ps`.
- `rt_addr`  in  AW  address being read as `rt` this cycle.
- `fwd_ra_hit` / `fwd_ra`  out  1 / `DATA_WIDTH`  a pending write to register 0 exists, and its value.
- `fwd_rt_hit` / `fwd_rt`  out  1 / `DATA_WIDTH`  a pending write to `rt_addr` exists, and its value.
- `fwd_ps_hit` / `fwd_ps`  out  1 / 1  a pending ps write exists, and its value.
- `empty`  out  1  no stored entries.
- `count`  out  `$clog2(DEPTH)+1`  stored entries.

## Operation

- Entry contents: {wr, addr, data, ps_wr, ps}.
- Enqueue: an entry is pushed when `in_valid && in_ready`.
  - If the accepted beat has `in_write=0` and `in_ps_write=0`, it is consumed and not stored.
- Readiness: `in_ready = (count < DEPTH) || !hold`. When full, an unheld drain frees a slot in the same cycle.
- Drain: every cycle with `count>0 && !hold`, the head entry is presented on `w` and popped at the clock edge.
  - `w.write = head.wr`, `w.ps_write = head.ps_wr`; `rw`, `rw_addr` and `ps` come from the head.
  - When nothing drains (`empty` or `hold`), `w.write=0` and `w.ps_write=0`, and the data fields hold 0.
- Simultaneous push and pop: `count` is unchanged, pointers advance, and the pushed entry lands behind the popped one.
- Ordering is strictly FIFO, so writes reach the regfile in issue order.
- Forwarding scans all stored entries, including the head being drained this cycle:
  - `fwd_rt_hit` is set if any valid entry has `wr && addr==rt_addr`. `fwd_rt` is the data of the youngest such entry.
  - `fwd_ra` is the same lookup with the address fixed at 0.
  - `fwd_ps_hit` / `fwd_ps` is the youngest entry with `ps_wr`.
  - The beat being enqueued in the same cycle is not visible to forwarding until the next cycle.
  - When there is no hit, the forward value is 0.
- Reset, asynchronous and active-high, clears the queue. Outputs under reset:
  - `count=0`, `empty=1`, `in_ready=1`.
  - `w.write=0`, `w.ps_write=0`, `w.rw=0`, `w.rw_addr=0`, `w.ps=0`.
  - All `fwd_*` outputs 0.
  - Entries in flight when reset asserts are discarded.

## Timing

- Latency: a result accepted at edge N appears on `w` during cycle N+1 if the queue was empty and `hold=0`. The regfile commits it at edge N+2.
- Each cycle of `hold` adds one cycle of latency.
- All `w.*` outputs come from registered queue state. There is no combinational path from `in_*` to `w.*`.
- Forwarding is combinational from `rt_addr` and the stored state, so `rt_addr` to `fwd_rt` is a combinational path.
- `in_ready` depends combinationally on `hold`.
- Throughput: one accept and one drain per cycle, sustained.

## Structure

- Shared package `nand_cpu_pkg` holds `typedef struct packed wb_entry_t {wr, addr, data, ps_wr, ps}` and `WB_DEPTH` (default 4).
- Sub-module `wb_queue` is a generic registered FIFO of `wb_entry_t` with push/pop, count and head, and exposes all entry slots plus their age order for the lookup.
- The forwarding priority search (youngest-first) lives in `regfile_writeback`.

## Test plan

- Reset mid-stream: fill 3 entries, assert `rst` asynchronously between edges → `count` and all `w.*`/`fwd_*` outputs are 0 immediately and `in_ready=1`.
- Single write: push {wr=1, addr=5, data=0xA5} at edge 0 with `hold=0` → cycle 1 shows `w.write=1`, `rw_addr=5`, `rw=0xA5`; cycle 2 shows `w.write=0`, `empty=1`.
- Forward youngest: with `hold=1`, push addr 3 = 0x11, then addr 3 = 0x22; set `rt_addr=3` → `fwd_rt_hit=1`, `fwd_rt=0x22`. Release hold → writes drain in order 0x11 then 0x22.
- Full and hold: with `hold=1`, push 4 entries → `count=4`, `in_ready=0`. Drop `hold` with `in_valid=1` → `in_ready=1`, and push and pop occur in the same cycle with `count` staying 4.
- ps-only and empty beats: push {ps_wr=1, ps=1} and then {wr=0, ps_wr=0} → only one entry is stored; `fwd_ps_hit=1`, `fwd_ps=1`; the drain shows `w.ps_write=1`, `w.write=0`.
- ra forwarding: push addr 0 = 0xFF with hold → `fwd_ra_hit=1`, `fwd_ra=0xFF`, `fwd_rt_hit=0` for `rt_addr=1`.
